sync_debounce: RTL and testbench
================================

// Module: sync_debounce
//
// PURPOSE
// - Multi-channel input conditioner for asynchronous board signals (buttons, switches, ext. strobes).
// - Per channel: STAGES-deep metastability chain, then a debounce filter, then registered edge pulses.
// - Sits between FPGA input pins and sysclk-domain control logic.
// - Successor of the plain sync chain: adds async reset, a reset value, filtering and edge detection.
//
// PARAMETERS
// - WIDTH           default 1   number of independent channels
// - STAGES          default 2   synchronizer flops per channel; <2 is an elaboration error
// - DEBOUNCE_CYCLES default 1   consecutive cycles a new level must persist; <1 is an elaboration error
// - RESET_VALUE     default 0   WIDTH-bit value loaded into every sync stage and db_out on reset
//
// PORTS
// - sysclk    in   1      single clock; all state on rising edge
// - rst_n     in   1      asynchronous, active-low reset
// - async_in  in   WIDTH  asynchronous inputs
// - sync_out  out  WIDTH  raw synchronized level (last sync stage), unfiltered
// - db_out    out  WIDTH  debounced stable level
// - rise      out  WIDTH  1-cycle pulse when db_out bit goes 0->1
// - fall      out  WIDTH  1-cycle pulse when db_out bit goes 1->0
//
// BEHAVIOUR
// - Reset (rst_n=0, async): all sync stages and db_out = RESET_VALUE; counters = 0; rise = fall = 0.
//   Held while rst_n low; no rise/fall may fire on the first cycles after release.
// - Sync chain: stage0 <= async_in, stage[i] <= stage[i-1]; sync_out = stage[STAGES-1].
// - Debounce, per channel, counter cnt width max(1,$clog2(DEBOUNCE_CYCLES)):
//   * sync_out == db_out          : cnt <= 0.
//   * sync_out != db_out, cnt <  DEBOUNCE_CYCLES-1 : cnt <= cnt+1.
//   * sync_out != db_out, cnt == DEBOUNCE_CYCLES-1 : db_out <= sync_out, cnt <= 0.
//   * Any return to db_out level before terminal count resets cnt -> glitch rejected.
// - Edges: rise/fall registered, asserted on the same edge db_out changes, for exactly one cycle.
//   rise and fall of one channel never both high. No pulse without a db_out change.
// - Latency: async_in stable before edge E0 -> sync_out changes at E(STAGES-1),
//   db_out/rise/fall at E(STAGES-1+DEBOUNCE_CYCLES). DEBOUNCE_CYCLES=1 -> db_out lags sync_out by 1.
// - Channels fully independent; simultaneous changes on several bits handled in parallel.
// - Input toggling every cycle with DEBOUNCE_CYCLES>1: db_out never changes.
// - Reset mid-count: counter discarded, db_out back to RESET_VALUE, no pulse emitted.
//
// STRUCTURE
// - Shared header: clog2-safe counter width macro/function; no other shared constants.
// - Sub-module debounce_channel (1 bit: sync chain, counter, db/rise/fall flops),
//   instantiated WIDTH times via generate; top only splits buses and passes parameters.
//
// TESTING  (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=4'h0 unless noted)
// - Reset: rst_n=0, async_in=4'hF -> sync_out=db_out=0, rise=fall=0 throughout; release -> no pulse.
// - Clean step: bit0 0->1 before E0 -> sync_out[0]=1 at E1, db_out[0]=1 and rise[0]=1 at E5, rise low at E6.
// - Glitch: bit1 high for 3 cycles then low -> db_out[1] stays 0, rise[1]=fall[1]=0; 4 cycles -> accepted.
// - Simultaneous: bit2 0->1 and bit3 1->0 (after settling) same cycle -> rise[2] and fall[3] same edge.
// - Reset mid-count: bit0 high, rst_n pulsed low at count 2 -> db_out=0, no rise; after release
//   full 4-cycle count restarts.
// - Param variant RESET_VALUE=4'hA, DEBOUNCE_CYCLES=1: reset -> db_out=4'hA; async_in=4'h5 ->
//   db_out=4'h5 at E2, rise=4'h5, fall=4'hA for one cycle.

Source files
------------

// File: rtl/sync_debounce_pkg.sv
// Shared types and helpers for the sync_debounce input conditioner.
// Holds the counter width function and the per-channel output bundle.
package sync_debounce_pkg;

    // Counter must be at least one bit wide even when DEBOUNCE_CYCLES is 1.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic sync;
        logic db;
        logic rise;
        logic fall;
    } chan_out_t;

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: metastability chain, persistence filter, registered edge pulses.
// db/rise/fall land STAGES-1+DEBOUNCE_CYCLES edges after the input settles.
module debounce_channel
    import sync_debounce_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 1,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic      sysclk,
    input  logic      rst_n,
    input  logic      async_i,
    output chan_out_t chan_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("debounce_channel: STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              db_q, db_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              settled;

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], async_i};
        settled = sync_q[STAGES-1];
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any return to the current level before terminal count drops the count.
        if (settled == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            db_d   = settled;
            cnt_d  = '0;
            rise_d = settled;
            fall_d = ~settled;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_BIT}};
            cnt_q  <= '0;
            db_q   <= RESET_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign chan_o.sync = sync_q[STAGES-1];
    assign chan_o.db   = db_q;
    assign chan_o.rise = rise_q;
    assign chan_o.fall = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debouncer + edge detector for asynchronous board inputs.
// Latency STAGES-1+DEBOUNCE_CYCLES edges to db_out/rise/fall; no backpressure, channels independent.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    chan_out_t chan [WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[g])
        ) u_chan (
            .sysclk  (sysclk),
            .rst_n   (rst_n),
            .async_i (async_in[g]),
            .chan_o  (chan[g])
        );

        assign sync_out[g] = chan[g].sync;
        assign db_out[g]   = chan[g].db;
        assign rise[g]     = chan[g].rise;
        assign fall[g]     = chan[g].fall;
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default-ish config plus a RESET_VALUE/1-cycle variant.
module tb_sync_debounce;

    logic       sysclk = 1'b0;
    logic       rst_n, rst_n_v;
    logic [3:0] a_in, sync_o, db_o, rise_o, fall_o;
    logic [3:0] a_v, sync_v, db_v, rise_v, fall_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    sync_debounce #(
        .WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'h0)
    ) u_dut (
        .sysclk(sysclk), .rst_n(rst_n), .async_in(a_in),
        .sync_out(sync_o), .db_out(db_o), .rise(rise_o), .fall(fall_o)
    );

    sync_debounce #(
        .WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(4'hA)
    ) u_dut_v (
        .sysclk(sysclk), .rst_n(rst_n_v), .async_in(a_v),
        .sync_out(sync_v), .db_out(db_v), .rise(rise_v), .fall(fall_v)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // Pulses must match observed db_out transitions, and stay quiet around reset.
    logic [3:0] mon_prev_db  = 4'h0;
    logic       mon_prev_rst = 1'b0;
    always @(negedge sysclk) begin
        if (rst_n && mon_prev_rst) begin
            chk("mon_rise", 32'(rise_o), 32'(db_o & ~mon_prev_db));
            chk("mon_fall", 32'(fall_o), 32'(~db_o & mon_prev_db));
        end else begin
            chk("mon_rise_rst", 32'(rise_o), 32'h0);
            chk("mon_fall_rst", 32'(fall_o), 32'h0);
        end
        mon_prev_db  = db_o;
        mon_prev_rst = rst_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rst_n_v = 1'b0;
        a_in    = 4'hF;
        a_v     = 4'h5;

        // Reset holds everything at RESET_VALUE regardless of input.
        step(3);
        chk("rst_sync", 32'(sync_o), 32'h0);
        chk("rst_db",   32'(db_o),   32'h0);
        chk("rst_rise", 32'(rise_o), 32'h0);
        chk("rst_fall", 32'(fall_o), 32'h0);
        chk("rstv_db",   32'(db_v),   32'hA);
        chk("rstv_sync", 32'(sync_v), 32'hA);

        a_in  = 4'h0;
        rst_n = 1'b1;
        step(8);
        chk("rel_db",   32'(db_o),   32'h0);
        chk("rel_sync", 32'(sync_o), 32'h0);

        // Clean step on bit0.
        a_in = 4'h1;
        step(1);
        chk("step_e0_sync", 32'(sync_o), 32'h0);
        step(1);
        chk("step_e1_sync", 32'(sync_o), 32'h1);
        chk("step_e1_db",   32'(db_o),   32'h0);
        step(3);
        chk("step_e4_db",   32'(db_o),   32'h0);
        chk("step_e4_rise", 32'(rise_o), 32'h0);
        step(1);
        chk("step_e5_db",   32'(db_o),   32'h1);
        chk("step_e5_rise", 32'(rise_o), 32'h1);
        step(1);
        chk("step_e6_rise", 32'(rise_o), 32'h0);
        chk("step_e6_db",   32'(db_o),   32'h1);

        // Three-cycle glitch on bit1 is rejected.
        a_in = 4'h3;
        step(3);
        a_in = 4'h1;
        step(8);
        chk("glitch3_db", 32'(db_o), 32'h1);

        // Four-cycle pulse on bit1 is accepted, then falls back.
        a_in = 4'h3;
        step(4);
        a_in = 4'h1;
        step(1);
        chk("glitch4_e4_db", 32'(db_o), 32'h1);
        step(1);
        chk("glitch4_e5_db",   32'(db_o),   32'h3);
        chk("glitch4_e5_rise", 32'(rise_o), 32'h2);
        step(4);
        chk("glitch4_e9_db",   32'(db_o),   32'h1);
        chk("glitch4_e9_fall", 32'(fall_o), 32'h2);

        // Simultaneous rise on bit2 and fall on bit3.
        a_in = 4'h9;
        step(8);
        chk("sim_settle_db", 32'(db_o), 32'h9);
        a_in = 4'h5;
        step(5);
        chk("sim_e4_db", 32'(db_o), 32'h9);
        step(1);
        chk("sim_e5_db",   32'(db_o),   32'h5);
        chk("sim_e5_rise", 32'(rise_o), 32'h4);
        chk("sim_e5_fall", 32'(fall_o), 32'h8);

        // Reset in the middle of a count.
        a_in = 4'h0;
        step(8);
        chk("mid_pre_db", 32'(db_o), 32'h0);
        a_in = 4'h1;
        step(4);
        chk("mid_cnt2_sync", 32'(sync_o), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_db",   32'(db_o),   32'h0);
        chk("mid_rst_sync", 32'(sync_o), 32'h0);
        rst_n = 1'b1;
        step(5);
        chk("mid_f4_db",   32'(db_o),   32'h0);
        chk("mid_f4_rise", 32'(rise_o), 32'h0);
        step(1);
        chk("mid_f5_db",   32'(db_o),   32'h1);
        chk("mid_f5_rise", 32'(rise_o), 32'h1);

        // Variant: RESET_VALUE=A, single-cycle debounce.
        rst_n_v = 1'b1;
        step(1);
        chk("var_e0_sync", 32'(sync_v), 32'hA);
        step(1);
        chk("var_e1_sync", 32'(sync_v), 32'h5);
        chk("var_e1_db",   32'(db_v),   32'hA);
        chk("var_e1_rise", 32'(rise_v), 32'h0);
        step(1);
        chk("var_e2_db",   32'(db_v),   32'h5);
        chk("var_e2_rise", 32'(rise_v), 32'h5);
        chk("var_e2_fall", 32'(fall_v), 32'hA);
        step(1);
        chk("var_e3_rise", 32'(rise_v), 32'h0);
        chk("var_e3_fall", 32'(fall_v), 32'h0);
        chk("var_e3_db",   32'(db_v),   32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
